flag_unit_stack: RTL and testbench

//  Next-generation ALU status-flag register. Width-parametrised; adds an overflow flag V,
//  per-flag update masking, a direct flag load, and a LIFO of flag snapshots for CALL/RET
//  and interrupt entry/exit. Sits between the ALU result/carry outputs and the control

---
 rtl/flag_pkg.sv | 14 +
 rtl/flag_lifo.sv | 63 ++++++
 rtl/flag_unit_stack.sv | 109 ++++++++++
 tb/tb_flag_unit_stack.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Flag bit layout for the status-flag register.
// The control unit's condition decoder uses the same layout.
package flag_pkg;

    localparam int NUM_FLAGS = 5;
    localparam int FLG_C     = 0;
    localparam int FLG_N     = 1;
    localparam int FLG_Z     = 2;
    localparam int FLG_P     = 3;
    localparam int FLG_V     = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/flag_lifo.sv
// Register-array LIFO for flag snapshots; dout always shows the top entry.
// Overflow and underflow are silently ignored here; the parent flags them.
module flag_lifo #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop && !push && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_do_push && (r_count == CW'(i))) begin
                r_mem[i] <= din;
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_count == CW'(i + 1)) begin
                dout = r_mem[i];
            end
        end
    end

    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

endmodule

// File: rtl/flag_unit_stack.sv
// ALU status-flag register with masked update, direct load and a snapshot
// LIFO for CALL/RET and interrupt entry/exit.
module flag_unit_stack
    import flag_pkg::*;
#(
    parameter int MAX_WIDTH = 8,
    parameter int PAR_WIDTH = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enaf,
    input  logic [NUM_FLAGS-1:0] upd_mask,
    input  logic [MAX_WIDTH-1:0] dataa,
    input  logic                 carry,
    input  logic                 ovf,
    input  logic                 load,
    input  logic [NUM_FLAGS-1:0] flags_in,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic                 C,
    output logic                 N,
    output logic                 Z,
    output logic                 P,
    output logic                 V,
    output logic [NUM_FLAGS-1:0] flags,
    output logic                 stk_full,
    output logic                 stk_empty,
    output logic                 stk_err
);

    localparam int CW = $clog2(DEPTH + 1);

    flags_t        r_flags;
    logic          r_err;
    flags_t        w_alu_flags;
    flags_t        w_masked;
    flags_t        w_top;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err_set;

    always_comb begin
        w_alu_flags        = '0;
        w_alu_flags[FLG_C] = carry;
        w_alu_flags[FLG_N] = dataa[MAX_WIDTH-1];
        w_alu_flags[FLG_Z] = (dataa == '0);
        w_alu_flags[FLG_P] = ~^dataa[PAR_WIDTH-1:0];
        w_alu_flags[FLG_V] = ovf;
    end

    assign w_masked  = (upd_mask & w_alu_flags) | (~upd_mask & r_flags);

    // A simultaneous push and pop is rejected outright rather than serialised.
    assign w_push_ok = push && !pop && !w_full;
    assign w_pop_ok  = pop && !push && !w_empty;
    assign w_err_set = (push && pop) || (push && w_full) || (pop && w_empty);

    flag_lifo #(
        .WIDTH (NUM_FLAGS),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_ok),
        .pop   (w_pop_ok),
        .din   (r_flags),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_flags <= w_top;
            end else if (load) begin
                r_flags <= flags_in;
            end else if (enaf) begin
                r_flags <= w_masked;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign C         = r_flags[FLG_C];
    assign N         = r_flags[FLG_N];
    assign Z         = r_flags[FLG_Z];
    assign P         = r_flags[FLG_P];
    assign V         = r_flags[FLG_V];
    assign flags     = r_flags;
    assign stk_full  = (w_count == CW'(DEPTH));
    assign stk_empty = (w_count == '0);
    assign stk_err   = r_err;

endmodule

// File: tb/tb_flag_unit_stack.sv
// Self-checking bench for flag_unit_stack (MAX_WIDTH=8, PAR_WIDTH=4, DEPTH=4).
module tb_flag_unit_stack;

    logic       clk = 1'b0;
    logic       rst, enaf, carry, ovf, load, push, pop, err_clr;
    logic [4:0] upd_mask, flags_in, flags;
    logic [7:0] dataa;
    logic       C, N, Z, P, V, stk_full, stk_empty, stk_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flag_unit_stack #(.MAX_WIDTH(8), .PAR_WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enaf(enaf), .upd_mask(upd_mask), .dataa(dataa),
        .carry(carry), .ovf(ovf), .load(load), .flags_in(flags_in), .push(push),
        .pop(pop), .err_clr(err_clr), .C(C), .N(N), .Z(Z), .P(P), .V(V),
        .flags(flags), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    typedef struct {
        logic       rst, enaf, carry, ovf, load, push, pop, err_clr;
        logic [4:0] mask, fin;
        logic [7:0] dataa;
        logic [4:0] e_flags;
        logic       e_full, e_empty, e_err;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] flags;
        logic       full, empty, err;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    // Operation word: {rst, enaf, load, push, pop, err_clr}
    function automatic vec_t mk(input logic [5:0] op, input logic [4:0] mask,
                                input logic [7:0] d, input logic cy, input logic ov,
                                input logic [4:0] fin, input logic [4:0] ef,
                                input logic efull, input logic eempty, input logic eerr);
        vec_t v;
        v.rst = op[5]; v.enaf = op[4]; v.load = op[3];
        v.push = op[2]; v.pop = op[1]; v.err_clr = op[0];
        v.mask = mask; v.dataa = d; v.carry = cy; v.ovf = ov; v.fin = fin;
        v.e_flags = ef; v.e_full = efull; v.e_empty = eempty; v.e_err = eerr;
        return v;
    endfunction

    task automatic check1(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        rst = v.rst; enaf = v.enaf; load = v.load; push = v.push; pop = v.pop;
        err_clr = v.err_clr; upd_mask = v.mask; dataa = v.dataa; carry = v.carry;
        ovf = v.ovf; flags_in = v.fin;
        e.name = name; e.flags = v.e_flags; e.full = v.e_full;
        e.empty = v.e_empty; e.err = v.e_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check1({e.name, ".flags"}, flags, e.flags);
            check1({e.name, ".indiv"}, {V, P, Z, N, C}, e.flags);
            check1({e.name, ".full"}, {4'b0, stk_full}, {4'b0, e.full});
            check1({e.name, ".empty"}, {4'b0, stk_empty}, {4'b0, e.empty});
            check1({e.name, ".err"}, {4'b0, stk_err}, {4'b0, e.err});
        end
    endtask

    localparam logic [5:0] OP_RST  = 6'b100000;
    localparam logic [5:0] OP_ENAF = 6'b010000;
    localparam logic [5:0] OP_LOAD = 6'b001000;
    localparam logic [5:0] OP_PUSH = 6'b000100;
    localparam logic [5:0] OP_POP  = 6'b000010;
    localparam logic [5:0] OP_CLR  = 6'b000001;
    localparam logic [5:0] OP_NONE = 6'b000000;

    initial begin
        rst = 1; enaf = 0; load = 0; push = 0; pop = 0; err_clr = 0;
        upd_mask = 0; dataa = 0; carry = 0; ovf = 0; flags_in = 0;

        tbl.push_back(mk(OP_RST, 0, 8'h00, 0, 0, 0, 5'b00000, 0, 1, 0));
        tbl.push_back(mk(OP_ENAF, 5'b11111, 8'h80, 1, 1, 0, 5'b11011, 0, 1, 0));
        tbl.push_back(mk(OP_ENAF, 5'b00100, 8'h00, 0, 0, 0, 5'b11111, 0, 1, 0));
        tbl.push_back(mk(OP_LOAD, 0, 8'h00, 0, 0, 5'b00001, 5'b00001, 0, 1, 0));
        tbl.push_back(mk(OP_LOAD | OP_PUSH, 0, 8'h00, 0, 0, 5'b10110, 5'b10110, 0, 0, 0));
        tbl.push_back(mk(OP_POP, 0, 8'h00, 0, 0, 0, 5'b00001, 0, 1, 0));
        tbl.push_back(mk(OP_POP | OP_ENAF, 5'b11111, 8'h00, 0, 0, 0, 5'b01100, 0, 1, 1));
        tbl.push_back(mk(OP_CLR, 0, 8'h00, 0, 0, 0, 5'b01100, 0, 1, 0));
        tbl.push_back(mk(OP_LOAD | OP_PUSH, 0, 8'h00, 0, 0, 5'b00011, 5'b00011, 0, 0, 0));
        tbl.push_back(mk(OP_LOAD | OP_PUSH, 0, 8'h00, 0, 0, 5'b10101, 5'b10101, 0, 0, 0));
        tbl.push_back(mk(OP_PUSH | OP_POP | OP_ENAF, 5'b00001, 8'h00, 0, 0, 0, 5'b10100, 0, 0, 1));
        tbl.push_back(mk(OP_POP | OP_LOAD, 0, 8'h00, 0, 0, 5'b11111, 5'b00011, 0, 0, 1));
        tbl.push_back(mk(OP_PUSH | OP_POP | OP_CLR, 0, 8'h00, 0, 0, 0, 5'b00011, 0, 0, 1));
        tbl.push_back(mk(OP_CLR, 0, 8'h00, 0, 0, 0, 5'b00011, 0, 0, 0));
        tbl.push_back(mk(OP_POP, 0, 8'h00, 0, 0, 0, 5'b01100, 0, 1, 0));
        tbl.push_back(mk(OP_ENAF, 5'b01000, 8'h07, 0, 0, 0, 5'b00100, 0, 1, 0));
        tbl.push_back(mk(OP_ENAF, 5'b01010, 8'h83, 0, 0, 0, 5'b01110, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Fill to DEPTH, then one push too many; count must stay at 4.
        for (int i = 1; i <= 4; i++) begin
            step(mk(OP_PUSH, 0, 8'h00, 0, 0, 0, 5'b01110, i == 4, 0, 0),
                 $sformatf("fill%0d", i));
        end
        step(mk(OP_PUSH, 0, 8'h00, 0, 0, 0, 5'b01110, 1, 0, 1), "ovfl");
        step(mk(OP_CLR, 0, 8'h00, 0, 0, 0, 5'b01110, 1, 0, 0), "ovfl_clr");
        step(mk(OP_POP, 0, 8'h00, 0, 0, 0, 5'b01110, 0, 0, 0), "drain1");
        step(mk(OP_POP, 0, 8'h00, 0, 0, 0, 5'b01110, 0, 0, 0), "drain2");

        // Reset with two entries held and all flags set discards everything.
        step(mk(OP_LOAD, 0, 8'h00, 0, 0, 5'b11111, 5'b11111, 0, 0, 0), "preset");
        step(mk(OP_RST | OP_LOAD | OP_PUSH, 0, 8'h00, 0, 0, 5'b11111, 5'b00000, 0, 1, 0), "rst2");
        step(mk(OP_POP, 0, 8'h00, 0, 0, 0, 5'b00000, 0, 1, 1), "post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
